// File: rtl/rr_arbiter8_onehot.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_onehot
//   Eight-requester round-robin arbiter with a bounded hold time. The grant is
//   registered one-hot, with its 3-bit encoded index alongside it. The search
//   for the next owner starts at a rotating pointer. The pointer advances past
//   an owner only when that owner releases or is preempted. An owner that has
//   held for MAX_HOLD cycles while others are waiting is forcibly rotated out.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles while others wait (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         arbitration enable; low blocks new grants and preemption
//   req[7:0]   request vector, req[i] high = requester i wants/keeps resource
//   gnt[7:0]   registered one-hot grant, zero when there is no owner
//   gnt_idx    encoded owner index, meaningful while gnt_valid is high
//   gnt_valid  high while an owner exists
//   preempt    one-cycle pulse alongside the first cycle of a forced rotation
// ---------------------------------------------------------------------------
module rr_arbiter8_onehot #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
    logic [2:0]       idx_n;
    logic             valid_n;
    logic             preempt_n;
    logic [7:0]       gnt_n;

    logic [2:0]       next_start;
    logic [7:0]       others;
    logic             owner_req;
    logic [2:0]       win_idle, win_release, win_preempt;

    // First set bit of r at or after 'start', wrapping 7 -> 0. The vector is
    // rotated so that 'start' lands at bit 0, then a plain priority encoder
    // finds the offset. Callers guarantee r is non-zero when the result is used.
    function automatic logic [2:0] first_from(input logic [7:0] r, input logic [2:0] start);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  off;
        dbl = {r, r} >> start;
        rot = dbl[7:0];
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        return start + off;   // 3-bit add wraps modulo 8
    endfunction

    assign next_start  = gnt_idx + 3'd1;
    assign others      = req & ~(8'h01 << gnt_idx);
    assign owner_req   = req[gnt_idx];
    assign win_idle    = first_from(req, ptr);
    assign win_release = first_from(req, next_start);
    assign win_preempt = first_from(others, next_start);

    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        idx_n      = gnt_idx;
        valid_n    = gnt_valid;
        preempt_n  = 1'b0;

        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (en && (req != 8'h00)) begin
                    // Fresh grant: the pointer stays put.
                    state_n    = GRANT;
                    idx_n      = win_idle;
                    valid_n    = 1'b1;
                    hold_cnt_n = '0;
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Release. req[owner] is low, so searching req from the
                    // next index cannot pick the old owner again.
                    ptr_n = next_start;
                    if (en && (req != 8'h00)) begin
                        idx_n      = win_release;
                        hold_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end else if (en && (hold_cnt == CNT_MAX) && (others != 8'h00)) begin
                    ptr_n      = next_start;
                    idx_n      = win_preempt;
                    hold_cnt_n = '0;
                    preempt_n  = 1'b1;
                end else if (hold_cnt != CNT_MAX) begin
                    // Saturate so a lone owner can hold indefinitely while the
                    // preempt condition remains armed.
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase

        gnt_n = valid_n ? (8'h01 << idx_n) : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_cnt_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            preempt   <= preempt_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8_onehot.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8_onehot
//   Three arbiters (MAX_HOLD = 1, 4, 16) share one stimulus stream. A
//   behavioural model tracks owner, pointer and cycles-held for each one, and
//   every cycle the outputs of all three are compared with the model.
//   Directed sequences cover the listed scenarios, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8_onehot;

    localparam int MH [3] = '{1, 4, 16};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt       [3];
    logic [2:0] gnt_idx   [3];
    logic       gnt_valid [3];
    logic       preempt   [3];

    always #5 clk = ~clk;

    rr_arbiter8_onehot #(.MAX_HOLD(1), .CNT_W(8)) u_mh1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt[0]), .gnt_idx(gnt_idx[0]), .gnt_valid(gnt_valid[0]), .preempt(preempt[0]));
    rr_arbiter8_onehot #(.MAX_HOLD(4), .CNT_W(8)) u_mh4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt[1]), .gnt_idx(gnt_idx[1]), .gnt_valid(gnt_valid[1]), .preempt(preempt[1]));
    rr_arbiter8_onehot #(.MAX_HOLD(16), .CNT_W(8)) u_mh16 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt[2]), .gnt_idx(gnt_idx[2]), .gnt_valid(gnt_valid[2]), .preempt(preempt[2]));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner [3] = '{-1, -1, -1};   // -1 = no owner
    int m_ptr   [3] = '{0, 0, 0};
    int m_held  [3] = '{0, 0, 0};      // cycles the current owner has held
    bit m_pre   [3] = '{0, 0, 0};

    function automatic int search(input logic [7:0] r, input int start);
        for (int j = 0; j < 8; j++) begin
            int i;
            i = (start + j) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            m_pre[d] = 1'b0;
            if (rst) begin
                m_owner[d] = -1;
                m_ptr[d]   = 0;
                m_held[d]  = 0;
            end else if (m_owner[d] < 0) begin
                if (en && req != 8'h00) begin
                    m_owner[d] = search(req, m_ptr[d]);
                    m_held[d]  = 1;
                end
            end else begin
                int         k;
                logic [7:0] rest;
                k    = m_owner[d];
                rest = req & ~(8'h01 << k);
                if (!req[k]) begin
                    m_ptr[d] = (k + 1) % 8;
                    if (en && req != 8'h00) begin
                        m_owner[d] = search(req, m_ptr[d]);
                        m_held[d]  = 1;
                    end else begin
                        m_owner[d] = -1;
                    end
                end else if (en && m_held[d] >= MH[d] && rest != 8'h00) begin
                    m_ptr[d]   = (k + 1) % 8;
                    m_owner[d] = search(rest, m_ptr[d]);
                    m_held[d]  = 1;
                    m_pre[d]   = 1'b1;
                end else begin
                    m_held[d] = m_held[d] + 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                logic [7:0] exp_gnt;
                exp_gnt = (m_owner[d] < 0) ? 8'h00 : (8'h01 << m_owner[d]);
                check($sformatf("mh%0d gnt", MH[d]), 32'(gnt[d]), 32'(exp_gnt));
                check($sformatf("mh%0d gnt_valid", MH[d]), 32'(gnt_valid[d]), 32'(m_owner[d] >= 0));
                check($sformatf("mh%0d preempt", MH[d]), 32'(preempt[d]), 32'(m_pre[d]));
                if (m_owner[d] >= 0)
                    check($sformatf("mh%0d gnt_idx", MH[d]), 32'(gnt_idx[d]), 32'(m_owner[d]));
                check($sformatf("mh%0d onehot0", MH[d]), 32'($onehot0(gnt[d])), 32'd1);
                check($sformatf("mh%0d decode", MH[d]), 32'(gnt[d]),
                      32'(gnt_valid[d] ? (8'h01 << gnt_idx[d]) : 8'h00));
            end
        end
    end

    // Apply inputs just after a falling edge and let n rising edges pass.
    task automatic cyc(input logic [7:0] r, input logic e, input logic rs, input int n);
        req = r;
        en  = e;
        rst = rs;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        cyc(8'h00, 1'b0, 1'b1, 2);
        check("reset gnt", 32'(gnt[1]), 32'h00);
        check("reset idx", 32'(gnt_idx[1]), 32'd0);

        // Single requester, then reset mid-grant.
        cyc(8'h04, 1'b1, 1'b0, 1);
        check("single gnt", 32'(gnt[1]), 32'h04);
        check("single idx", 32'(gnt_idx[1]), 32'd2);
        check("single valid", 32'(gnt_valid[1]), 32'd1);
        cyc(8'h04, 1'b1, 1'b1, 1);
        check("midreset gnt", 32'(gnt[1]), 32'h00);

        // Full load rotation, MAX_HOLD=4, including the 7 -> 0 wrap.
        cyc(8'hFF, 1'b1, 1'b0, 1);
        check("rot first", 32'(gnt[1]), 32'h01);
        cyc(8'hFF, 1'b1, 1'b0, 4);
        check("rot second", 32'(gnt[1]), 32'h02);
        check("rot preempt", 32'(preempt[1]), 32'd1);
        cyc(8'hFF, 1'b1, 1'b0, 24);
        check("rot owner7", 32'(gnt[1]), 32'h80);
        cyc(8'hFF, 1'b1, 1'b0, 4);
        check("rot wrap", 32'(gnt[1]), 32'h01);
        check("rot wrap preempt", 32'(preempt[1]), 32'd1);

        // Back-to-back release from owner 3 to owner 5.
        cyc(8'h00, 1'b0, 1'b1, 1);
        cyc(8'h08, 1'b1, 1'b0, 1);
        cyc(8'h2A, 1'b1, 1'b0, 2);
        check("b2b hold", 32'(gnt[1]), 32'h08);
        cyc(8'h22, 1'b1, 1'b0, 1);
        check("b2b gnt", 32'(gnt[1]), 32'h20);
        check("b2b no preempt", 32'(preempt[1]), 32'd0);

        // Lone owner 6 for 50 cycles, then contention, MAX_HOLD=16.
        cyc(8'h00, 1'b0, 1'b1, 1);
        cyc(8'h40, 1'b1, 1'b0, 50);
        check("lone hold", 32'(gnt[2]), 32'h40);
        cyc(8'h41, 1'b1, 1'b0, 1);
        check("lone to 0", 32'(gnt[2]), 32'h01);
        check("lone preempt", 32'(preempt[2]), 32'd1);

        // Enable gating from IDLE.
        cyc(8'h00, 1'b0, 1'b1, 1);
        cyc(8'h81, 1'b0, 1'b0, 3);
        check("en0 idle", 32'(gnt[1]), 32'h00);
        cyc(8'h81, 1'b1, 1'b0, 1);
        check("en1 grant", 32'(gnt[1]), 32'h01);

        // en=0 while owning: no preemption, release goes idle.
        cyc(8'h00, 1'b0, 1'b1, 1);
        cyc(8'h04, 1'b1, 1'b0, 1);
        cyc(8'h0C, 1'b0, 1'b0, 40);
        check("en0 hold", 32'(gnt[1]), 32'h04);
        check("en0 no preempt", 32'(preempt[1]), 32'd0);
        cyc(8'h08, 1'b0, 1'b0, 1);
        check("en0 release", 32'(gnt[1]), 32'h00);
        check("en0 release valid", 32'(gnt_valid[1]), 32'd0);

        // Random traffic: slowly changing requests, mostly enabled, rare reset.
        cyc(8'h00, 1'b0, 1'b1, 1);
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = req;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(63) == 0) r = 8'hFF;
            cyc(r, ($urandom_range(7) != 0), ($urandom_range(199) == 0), 1);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
